alu_op_arbiter: RTL
===================

Name: alu_op_arbiter

Overview:
- Shares one 8-bit add/sub ALU datapath between two requesters. Each requester presents an opcode and two operands.
- The block arbitrates round-robin and latches the winner's operands. It sequences the operation over a fixed execute latency, then returns result, flag and requester ID with a one-cycle done pulse.
- Sits between the requesting units and the shared arithmetic stage. All operation sequencing to that stage goes through this block.

Parameters:
- WIDTH, 8, operand/result width in bits.
- EXEC_CYCLES, 1, cycles spent in EXEC before the result is registered; legal range 1..15.

Ports:
- clock  input  1  single system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 operation request.
- op0  input  1  requester 0 opcode: 0 = add, 1 = subtract.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- req1, op1, a1, b1  input  1/1/WIDTH/WIDTH  requester 1 equivalents.
- grant  output  2  one-hot, one-cycle pulse: operands of that requester captured.
- done  output  1  one-cycle pulse: result valid.
- done_id  output  1  requester that owns the current result.
- result  output  WIDTH  registered ALU result.
- flag  output  1  add: carry-out; sub: borrow (A < B unsigned).
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (sync, checked every edge, priority over everything):
  - state = IDLE, grant = 0, done = 0, done_id = 0, result = 0, flag = 0, busy = 0.
  - Exec counter = 0; last-served pointer = 1, so requester 0 wins the first tie.
  - Reset asserted mid-operation aborts the operation: no done is produced, and the captured operands are discarded.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Requests are sampled only here.
  - Only req0 high: select 0. Only req1 high: select 1.
  - Both high: select the requester not equal to the last-served pointer.
  - At that edge: latch op/a/b of the winner and its ID, set grant[winner] = 1 for exactly one cycle, update the pointer to the winner, counter = 0, go to EXEC.
  - No request: stay in IDLE; all pulses low.
- Requester rules:
  - Hold req, op, a and b stable until grant is observed.
  - Drop req in the cycle after grant, unless a new operation is intended.
  - req is ignored in EXEC and RESP. A req still high when IDLE is re-entered is a new request.
- EXEC:
  - Counter increments each edge.
  - At the edge where counter == EXEC_CYCLES-1:
    - add: {flag, result} = A + B, (WIDTH+1)-bit sum.
    - sub: result = (A - B) mod 2^WIDTH, flag = (A < B).
  - At that same edge, done_id = latched ID, done = 1, go to RESP.
- RESP: done high for this one cycle only; next edge -> IDLE, done = 0.
- result, flag and done_id hold their values until the next done; they are not cleared on return to IDLE.
- Latency:
  - req sampled at edge N -> grant high during cycle N+1.
  - done high during cycle N+1+EXEC_CYCLES.
  - Earliest next sample: edge N+2+EXEC_CYCLES.
  - Throughput: one op per EXEC_CYCLES+2 cycles.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1...
- Operand changes after grant do not affect the in-flight result.
- busy = 1 in EXEC and RESP, 0 in IDLE (registered with state).

Test Plan:
- Reset then idle: hold reset 2 cycles, no req -> all outputs 0, busy 0, no grant/done for 10 cycles.
- Single add: req0=1, op0=0, a0=0xF0, b0=0x20 (EXEC_CYCLES=1) -> grant=01 next cycle; done=1 one cycle later with result=0x10, flag=1, done_id=0.
- Subtract with borrow: req1, op1=1, a1=0x05, b1=0x07 -> grant=10; result=0xFE, flag=1, done_id=1. Then a1=0x07, b1=0x05 -> result=0x02, flag=0.
- Contention: req0 and req1 held high continuously for 4 ops -> grants 01,10,01,10; each done_id matches its grant; done pulses spaced exactly 3 cycles apart.
- Operand change after grant: change a0 from 0x10 to 0xFF the cycle after grant (add, b0=0x01) -> result=0x11, flag=0.
- Reset mid-op: EXEC_CYCLES=4, assert reset during cycle 2 of EXEC -> no done ever pulses for that op; state IDLE; pointer=1, so next simultaneous request grants 01.

Source files
------------

// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter that shares one add/sub ALU between two requesters.
// It latches the winner's operands, runs a fixed execute latency, then returns the result with a done pulse.
//
// state | meaning
// IDLE  | sample requests, pick a winner, capture its operands
// EXEC  | count execute cycles, register result on the last one
// RESP  | done pulse cycle, return to IDLE next edge
module alu_op_arbiter #(
  parameter int WIDTH       = 8,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic             op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       grant,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result,
  output logic             flag,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic             last;
  logic             op_q;
  logic             id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic             any_req;
  logic             sel;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  // On a tie the requester not served last wins; otherwise whoever asks.
  always_comb begin
    any_req = req0 | req1;
    sel     = (req0 && req1) ? ~last : req1;
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      last    <= 1'b1;
      op_q    <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      grant   <= 2'b00;
      done    <= 1'b0;
      done_id <= 1'b0;
      result  <= '0;
      flag    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      grant <= 2'b00;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            id_q  <= sel;
            op_q  <= sel ? op1 : op0;
            a_q   <= sel ? a1 : a0;
            b_q   <= sel ? b1 : b0;
            grant <= sel ? 2'b10 : 2'b01;
            last  <= sel;
            cnt   <= 4'd0;
            state <= S_EXEC;
            busy  <= 1'b1;
          end
        end
        S_EXEC: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            // Subtract borrow is the top bit of the widened difference.
            if (op_q) begin
              result <= diff[WIDTH-1:0];
              flag   <= diff[WIDTH];
            end else begin
              result <= sum[WIDTH-1:0];
              flag   <= sum[WIDTH];
            end
            done_id <= id_q;
            done    <= 1'b1;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
